// File: rtl/ltc2308_ctrl.sv
// LTC2308 master: CONVST pulse, then 12 SCK cycles shifting cfg out on SDI and the result in from SDO.
// valid comes CONV_CYCLES+24*SCK_HALF cycles after CONVST rises; start is dropped unless ready is high.
module ltc2308_ctrl #(
    parameter int CONVST_HI   = 1,
    parameter int CONV_CYCLES = 81,
    parameter int SCK_HALF    = 1,
    parameter int CYC_CYCLES  = 110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cfg,
    output logic        ready,
    output logic        valid,
    output logic [11:0] data,
    output logic [5:0]  data_cfg,
    output logic        data_cfg_ok,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int CNT_W = $clog2(CYC_CYCLES + 1);
    localparam int PH_W  = $clog2(SCK_HALF) + 1;

    localparam logic [CNT_W-1:0] HI_C    = CNT_W'(CONVST_HI);
    localparam logic [CNT_W-1:0] CONV_C  = CNT_W'(CONV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CYC_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SCK_HALF - 1);

    if (CYC_CYCLES < CONV_CYCLES + 24 * SCK_HALF + 2 || CONVST_HI >= CONV_CYCLES ||
        CONVST_HI < 1 || SCK_HALF < 1) begin : g_bad_params
        $error("ltc2308_ctrl: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [PH_W-1:0]  ph, ph_nxt;
    logic [3:0]       bit_idx, bit_nxt;
    logic [5:0]       sdi_sr, sdi_sr_nxt;
    logic [11:0]      rx_sr;
    logic [5:0]       cfg_cur;
    logic [5:0]       cfg_prev;
    logic             prev_done;

    logic convst_nxt, sck_nxt, sdi_nxt;
    logic accept, sample, finish;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ph_nxt     = ph;
        bit_nxt    = bit_idx;
        sdi_sr_nxt = sdi_sr;
        convst_nxt = 1'b0;
        sck_nxt    = 1'b0;
        sdi_nxt    = 1'b0;
        accept     = 1'b0;
        sample     = 1'b0;
        finish     = 1'b0;
        cnt_inc    = cnt + 1'b1;

        case (state)
            IDLE: begin
                if (start && ready) begin
                    accept     = 1'b1;
                    state_nxt  = CONV;
                    cnt_nxt    = '0;
                    sdi_sr_nxt = cfg;
                    convst_nxt = 1'b1;
                end
            end

            CONV: begin
                cnt_nxt    = cnt_inc;
                convst_nxt = (cnt_inc < HI_C);
                // The first SCK low phase starts at cnt == CONV_CYCLES, so SDI must be valid then.
                if (cnt_inc == CONV_C) begin
                    state_nxt = SHIFT;
                    ph_nxt    = '0;
                    bit_nxt   = '0;
                    sdi_nxt   = sdi_sr[5];
                end
            end

            SHIFT: begin
                cnt_nxt = cnt_inc;
                sck_nxt = adc_sck;
                sdi_nxt = adc_sdi;
                if (ph == PH_LAST) begin
                    ph_nxt = '0;
                    if (!adc_sck) begin
                        sck_nxt = 1'b1;
                        sample  = 1'b1;
                    end else if (bit_idx == 4'd11) begin
                        sck_nxt   = 1'b0;
                        sdi_nxt   = 1'b0;
                        finish    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        sck_nxt    = 1'b0;
                        bit_nxt    = bit_idx + 4'd1;
                        sdi_nxt    = sdi_sr[4];
                        sdi_sr_nxt = {sdi_sr[4:0], 1'b0};
                    end
                end else begin
                    ph_nxt = ph + 1'b1;
                end
            end

            HOLD: begin
                cnt_nxt = cnt_inc;
                if (cnt == LAST_C) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset parks the FSM in HOLD at cnt 0, so the tCYC guard after reset reuses the frame tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HOLD;
            cnt         <= '0;
            ph          <= '0;
            bit_idx     <= '0;
            sdi_sr      <= '0;
            rx_sr       <= '0;
            cfg_cur     <= '0;
            cfg_prev    <= '0;
            prev_done   <= 1'b0;
            ready       <= 1'b0;
            valid       <= 1'b0;
            data        <= '0;
            data_cfg    <= '0;
            data_cfg_ok <= 1'b0;
            adc_convst  <= 1'b0;
            adc_sck     <= 1'b0;
            adc_sdi     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ph         <= ph_nxt;
            bit_idx    <= bit_nxt;
            sdi_sr     <= sdi_sr_nxt;
            ready      <= (state_nxt == IDLE);
            valid      <= finish;
            adc_convst <= convst_nxt;
            adc_sck    <= sck_nxt;
            adc_sdi    <= sdi_nxt;
            if (accept) begin
                cfg_cur <= cfg;
            end
            if (sample) begin
                rx_sr <= {rx_sr[10:0], adc_sdo};
            end
            // The device answers with the conversion set up by the previous frame's SDI word.
            if (finish) begin
                data        <= rx_sr;
                data_cfg    <= cfg_prev;
                data_cfg_ok <= prev_done;
                cfg_prev    <= cfg_cur;
                prev_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Directed + randomized bench for ltc2308_ctrl with a behavioural LTC2308 SDO driver and bus checker.
module tb_ltc2308_ctrl;

    localparam int CONVST_HI   = 1;
    localparam int CONV_CYCLES = 81;
    localparam int SCK_HALF    = 1;
    localparam int CYC_CYCLES  = 110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cfg = '0;
    logic        adc_sdo = 1'b0;
    logic        ready, valid, data_cfg_ok, adc_convst, adc_sck, adc_sdi;
    logic [11:0] data;
    logic [5:0]  data_cfg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [11:0] sdo_word = '0;
    logic [5:0]  prev_cfg = '0;
    logic        have_prev = 1'b0;

    ltc2308_ctrl #(
        .CONVST_HI  (CONVST_HI),
        .CONV_CYCLES(CONV_CYCLES),
        .SCK_HALF   (SCK_HALF),
        .CYC_CYCLES (CYC_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg        (cfg),
        .ready      (ready),
        .valid      (valid),
        .data       (data),
        .data_cfg   (data_cfg),
        .data_cfg_ok(data_cfg_ok),
        .adc_convst (adc_convst),
        .adc_sck    (adc_sck),
        .adc_sdi    (adc_sdi),
        .adc_sdo    (adc_sdo)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: B11 appears after CONVST rises, each later bit shortly after an SCK fall.
    int sdo_k = 0;
    always @(posedge adc_convst) begin
        sdo_k = 0;
        #2;
        adc_sdo = sdo_word[11];
    end
    always @(negedge adc_sck) begin
        #2;
        sdo_k++;
        adc_sdo = (sdo_k < 12) ? sdo_word[11 - sdo_k] : 1'b0;
    end

    // Bus timing checker in absolute time: tCYC >= 2us, tHCONVST, tCONV >= 1.6us, CONVST width.
    int   viol = 0;
    int   last_cv_rise = -100000;
    int   last_sck_fall = -100000;
    logic mon_cv = 1'b0;
    logic mon_sck = 1'b0;
    always @(negedge clk) begin
        if (adc_convst === 1'b1 && mon_cv === 1'b0) begin
            if (cyc - last_cv_rise < 100) viol++;
            if (cyc - last_sck_fall < 2) viol++;
            last_cv_rise = cyc;
        end
        if (adc_convst === 1'b0 && mon_cv === 1'b1 && cyc - last_cv_rise != CONVST_HI) viol++;
        if (adc_sck === 1'b1 && mon_sck === 1'b0 && cyc - last_cv_rise < 80) viol++;
        if (adc_sck === 1'b0 && mon_sck === 1'b1) last_sck_fall = cyc;
        mon_cv  = adc_convst;
        mon_sck = adc_sck;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted frame observed for 240 cycles; optional start pulse / reset at a given cnt.
    task automatic run_frame(input logic [5:0] c, input logic [11:0] w, input int pulse_at, input int rst_at);
        int t, nvalid, vat, nsck, sck_bad, sdi_bad, hi_cnt, new_rises, rdy_at, pins_at_rst;
        logic [11:0] vdata;
        logic [5:0]  vcfg;
        logic        vok, prev_sck, prev_cv, exp_sdi;
        t = 0;
        while (ready !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        check("frame_ready_before", ready, 1'b1);
        sdo_word = w;
        cfg      = c;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cfg   = 6'($urandom);
        check("frame_convst_at_cnt0", adc_convst, 1'b1);
        nvalid = 0; vat = -1; nsck = 0; sck_bad = 0; sdi_bad = 0; hi_cnt = 1;
        new_rises = 0; rdy_at = -1; pins_at_rst = -1;
        vdata = '0; vcfg = '0; vok = 1'b0;
        prev_sck = adc_sck;
        prev_cv  = adc_convst;
        for (int k = 1; k <= 240; k++) begin
            start = (k - 1 == pulse_at);
            rst   = (k - 1 == rst_at);
            tick();
            if (valid === 1'b1) begin
                nvalid++;
                vat   = k;
                vdata = data;
                vcfg  = data_cfg;
                vok   = data_cfg_ok;
            end
            if (adc_sck === 1'b1 && prev_sck === 1'b0) begin
                if (k != CONV_CYCLES + SCK_HALF * (2 * nsck + 1)) sck_bad++;
                exp_sdi = (nsck < 6) ? c[5 - nsck] : 1'b0;
                if (adc_sdi !== exp_sdi) sdi_bad++;
                nsck++;
            end
            if (adc_convst === 1'b1) begin
                if (prev_cv === 1'b0) new_rises++;
                else hi_cnt++;
            end
            if (ready === 1'b1 && rdy_at < 0) rdy_at = k;
            if (k == rst_at + 1) pins_at_rst = int'({adc_convst, adc_sck, adc_sdi, valid});
            prev_sck = adc_sck;
            prev_cv  = adc_convst;
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_at < 0) begin
            check("valid_count", nvalid, 1);
            check("valid_at_cnt", vat, CONV_CYCLES + 24 * SCK_HALF);
            check("data", vdata, w);
            check("data_cfg_ok", vok, have_prev);
            if (have_prev) check("data_cfg", vcfg, prev_cfg);
            check("sck_rise_count", nsck, 12);
            check("sck_rise_timing", sck_bad, 0);
            check("sdi_bits", sdi_bad, 0);
            check("convst_high_cycles", hi_cnt, CONVST_HI);
            check("ready_return_cnt", rdy_at, CYC_CYCLES);
            prev_cfg  = c;
            have_prev = 1'b1;
        end else begin
            check("rst_no_valid", nvalid, 0);
            check("rst_pins_low", pins_at_rst, 0);
            check("rst_ready_return", rdy_at, rst_at + 1 + CYC_CYCLES);
            have_prev = 1'b0;
        end
        check("no_extra_convst", new_rises, 0);
    endtask

    initial begin
        int t, ready_early, pins_active;
        int rise_at[10];
        logic [11:0] cur_word;

        // Reset and post-reset tCYC guard.
        repeat (3) tick();
        check("reset_outputs", {ready, valid, data, data_cfg, data_cfg_ok, adc_convst, adc_sck, adc_sdi}, '0);
        rst = 1'b0;
        ready_early = 0;
        pins_active = 0;
        for (int i = 1; i < CYC_CYCLES; i++) begin
            tick();
            if (ready !== 1'b0) ready_early++;
            if ({adc_convst, adc_sck, adc_sdi, valid} !== 4'b0) pins_active++;
        end
        check("ready_low_after_reset", ready_early, 0);
        check("pins_static_after_reset", pins_active, 0);
        tick();
        check("ready_at_cycle_110", ready, 1'b1);

        // Single frame from the test plan.
        run_frame(6'b100010, 12'hA5C, -1, -1);

        // Ten back-to-back frames with start held high.
        cur_word = 12'($urandom);
        sdo_word = cur_word;
        cfg      = 6'd0;
        start    = 1'b1;
        for (int n = 0; n < 10; n++) begin
            t = 0;
            while (adc_convst !== 1'b1 && t < 300) begin
                tick();
                t++;
            end
            check("b2b_convst_seen", adc_convst, 1'b1);
            rise_at[n] = cyc;
            cfg = 6'($urandom);
            t = 0;
            while (valid !== 1'b1 && t < 300) begin
                tick();
                t++;
            end
            check("b2b_valid_seen", valid, 1'b1);
            check("b2b_data", data, cur_word);
            check("b2b_data_cfg_ok", data_cfg_ok, have_prev);
            if (have_prev) check("b2b_data_cfg", data_cfg, prev_cfg);
            prev_cfg  = 6'(n);
            have_prev = 1'b1;
            cur_word  = 12'($urandom);
            sdo_word  = cur_word;
            cfg       = 6'(n + 1);
            if (n == 9) start = 1'b0;
            tick();
        end
        for (int n = 1; n < 10; n++) begin
            check("b2b_convst_period", rise_at[n] - rise_at[n-1], CYC_CYCLES + 1);
        end

        // start pulsed at cnt 40 is ignored.
        run_frame(6'($urandom), 12'($urandom), 40, -1);

        // Reset during SHIFT bit 5 (SCK high at cnt 92), then a frame with unknown device config.
        run_frame(6'($urandom), 12'($urandom), -1, CONV_CYCLES + SCK_HALF * 11);
        run_frame(6'($urandom), 12'($urandom), -1, -1);

        // SDO stuck low then high, then random frames.
        run_frame(6'($urandom), 12'h000, -1, -1);
        run_frame(6'($urandom), 12'hFFF, -1, -1);
        for (int r = 0; r < 3; r++) begin
            run_frame(6'($urandom), 12'($urandom), -1, -1);
        end

        check("bus_timing_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltc2308_ctrl.md
# ltc2308_ctrl

Synthesizable master controller for the LTC2308 12-bit SAR ADC on the DE10-Nano. It drives CONVST/SCK/SDI, captures SDO, and presents each result on a one-cycle valid strobe. It sits between fabric logic issuing `start` + 6-bit channel config and the ADC pins. All pin timing is derived from counters on a single clock: 50 MHz (20 ns) in the defaults.

## Interface
- `CONVST_HI`, default 1: CONVST high time in clk cycles; must give 20–40 ns.
- `CONV_CYCLES`, default 81: cycles from CONVST rise to first SCK activity; must be at least tCONV_MAX of 1.6 µs.
- `SCK_HALF`, default 1: SCK high time and low time in clk cycles; must give at least 10 ns each and a period of at least 25 ns.
- `CYC_CYCLES`, default 110: minimum cycles between CONVST rises; must be at least 2 µs. Elaboration `$error` if `CYC_CYCLES < CONV_CYCLES + 24*SCK_HALF + 2` or `CONVST_HI >= CONV_CYCLES`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a conversion; accepted when `start & ready`.
- `cfg`  in  6  {S/D, O/S, S1, S0, UNI, SLP}; shifted to SDI MSB first during this frame.
- `ready`  out  1  controller idle and tCYC satisfied.
- `valid`  out  1  one-cycle strobe; `data`/`data_cfg` are updated on the same edge.
- `data`  out  12  conversion result, MSB first from SDO.
- `data_cfg`  out  6  config that selected this result, i.e. `cfg` of the previous frame.
- `data_cfg_ok`  out  1  0 for the first result after reset, because the device config is unknown then.
- `adc_convst`  out  1  to ADC.
- `adc_sck`  out  1  to ADC.
- `adc_sdi`  out  1  to ADC.
- `adc_sdo`  in  1  from ADC.

## Operation
- States: IDLE, CONV, SHIFT, HOLD. A cycle counter `cnt` is 0 on the first cycle CONVST is high and increments every cycle outside IDLE.
- IDLE: `ready`=1. On `start & ready`, latch `cfg` into the shift register and go to CONV. On that edge `cnt` is 0 and `adc_convst` is 1.
- CONV: `adc_convst`=1 while `cnt < CONVST_HI`, then 0. At `cnt = CONV_CYCLES`, go to SHIFT.
- SHIFT: 12 bits, i = 0..11. Each bit is a low phase of SCK_HALF cycles followed by a high phase of SCK_HALF cycles.
  - `adc_sdi` = cfg bit 5−i for i < 6, else 0. It changes on the edge that lowers SCK.
  - `adc_sdo` is sampled on the clk edge that raises SCK. Bit 0 sampled is B11, bit 11 is B0.
- End of SHIFT: on the edge that completes bit 11's high phase, SCK goes low and `valid`=1.
  - `data` ← shifted value.
  - `data_cfg` ← previously latched frame cfg.
  - `data_cfg_ok` ← 1 if a prior frame completed since reset.
  - Then go to HOLD.
- HOLD: all pins low. When `cnt = CYC_CYCLES-1`, go to IDLE.
- `start` while `ready`=0 is ignored, not queued.
- `cfg` is sampled only at acceptance.

## Timing
- Reset values: `adc_convst`=0, `adc_sck`=0, `adc_sdi`=0, `valid`=0, `data`=0, `data_cfg`=0, `data_cfg_ok`=0, `ready`=0.
- After `rst` deasserts, `ready` stays 0 for CYC_CYCLES cycles, so an aborted frame cannot violate tCYC.
- Reset mid-operation: all pins go low on the next edge, no `valid` is produced, and the post-reset guard applies.
  - Reset during CONVST high truncates tWHCONV, which is unavoidable.
- Latencies with defaults:
  - CONVST high at `cnt` 0 only (20 ns).
  - SCK rises at `cnt` = 82 + 2i and falls at 83 + 2i.
  - `valid` at `cnt` = 81 + 24·SCK_HALF = 105.
  - `ready` returns at `cnt` = 110.
- With `start` held high, CONVST rises every CYC_CYCLES+1 = 111 cycles (2.22 µs).
- tHCONVST: CONVST stays low for at least 2 cycles after the last SCK fall.
- All outputs are registered, with no combinational path from `adc_sdo`.

## Test plan
- Reset release: all outputs 0, `ready`=0 for cycles 0–109, `ready`=1 at cycle 110, pins static.
- Single frame with `cfg`=6'b100010 and an SDO driver emitting 12'hA5C after SCK falls:
  - `valid` pulses once at `cnt`=105 with `data`=12'hA5C and `data_cfg_ok`=0.
  - SDI at SCK rises 1–12 reads 1,0,0,0,1,0,0,0,0,0,0,0.
- Ten back-to-back frames with `start`=1 and cfg incrementing from 0 to 9:
  - CONVST rises exactly 111 cycles apart.
  - Frame n reports `data_cfg`=n−1 and `data_cfg_ok`=1 for n ≥ 1.
  - The LTC2308 bus timing checker reports no violations.
- `start` pulsed at `cnt`=40 of an active frame: ignored, exactly one `valid`, next CONVST only after a fresh accept.
- `rst` asserted during SHIFT bit 5: pins 0 on the next edge, no `valid`, `ready` back after 110 cycles, next frame reports `data_cfg_ok`=0.
- SDO constant 0 then constant 1: `data`=12'h000 then 12'hFFF.
